freq_meter: RTL and testbench

Gated-window frequency counter that measures an asynchronous test signal against the 50 MHz system clock clk_in. It counts the rising edges of that signal over a fixed gate of GATE_CYCLES clk_in cycles and reports the count, a range verdict and an overflow flag. It is the consumer-side check for the divided clocks (1 kHz, 1 MHz, 25 MHz): it sits beside the clock generator and feeds status LEDs or self-test logic.

---
 rtl/freq_meter.sv | 223 ++++++++++++++++++++++
 tb/tb_freq_meter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Gated-window frequency counter. Counts rising edges of an
//             asynchronous test signal over a fixed gate of GATE_CYCLES
//             clk_in cycles, then publishes the count, a range verdict and a
//             saturation flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    GATE_CYCLES  gate length in clk_in cycles (>= 2)
//    CNT_W        width of the edge counter and of freq_cnt
//    EXP_LO       inclusive lower bound of the in-range window
//    EXP_HI       inclusive upper bound of the in-range window
//  Ports
//    clk_in    in   1      system clock
//    rst_n     in   1      asynchronous active-low reset
//    sig_in    in   1      signal under test (asynchronous to clk_in)
//    start     in   1      single-cycle measurement request (IDLE only)
//    cont      in   1      continuous mode, re-arms from DONE while high
//    busy      out  1      high in ARM / GATE / DONE
//    valid     out  1      one-cycle pulse when a result is published
//    freq_cnt  out  CNT_W  rising edges counted in the last gate
//    in_range  out  1      last result within [EXP_LO, EXP_HI], no overflow
//    overflow  out  1      edge counter saturated during the last gate
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16,
  parameter int EXP_LO      = 0,
  parameter int EXP_HI      = 65535
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             in_range,
  output logic             overflow
);

  // Gate counter only ever needs to reach GATE_CYCLES-1, so $clog2 bits
  // suffice and it never has to wrap.
  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam longint            CNT_MAX_L = (longint'(1) << CNT_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input path: two-flop synchronizer plus a history flop. Runs in every
  // state so the edge detector is already primed when a gate opens.
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic hist_q;
  logic edge_pulse;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_pulse = sync2_q & ~hist_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                ovf_q,      ovf_d;
  logic [CNT_W-1:0]    freq_q,     freq_d;
  logic                in_range_q, in_range_d;
  logic                ovf_out_q,  ovf_out_d;

  // Edge counter value after accounting for this cycle's edge, with
  // saturation: an edge arriving at full scale raises the overflow flag
  // instead of wrapping the count.
  logic [CNT_W-1:0] edge_cnt_upd;
  logic             ovf_upd;

  always_comb begin
    edge_cnt_upd = edge_cnt_q;
    ovf_upd      = ovf_q;
    if (edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_upd = 1'b1;
      end else begin
        edge_cnt_upd = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Range comparators. Bounds that cannot constrain a CNT_W-bit count are
  // resolved at elaboration so no always-true/always-false compare is built.
  // --------------------------------------------------------------------------
  logic lo_ok;
  logic hi_ok;

  generate
    if (EXP_LO <= 0) begin : g_lo_open
      assign lo_ok = 1'b1;
    end else if (longint'(EXP_LO) > CNT_MAX_L) begin : g_lo_never
      assign lo_ok = 1'b0;
    end else begin : g_lo_cmp
      assign lo_ok = (edge_cnt_upd >= CNT_W'(EXP_LO));
    end
  endgenerate

  generate
    if (longint'(EXP_HI) >= CNT_MAX_L) begin : g_hi_open
      assign hi_ok = 1'b1;
    end else if (EXP_HI < 0) begin : g_hi_never
      assign hi_ok = 1'b0;
    end else begin : g_hi_cmp
      assign hi_ok = (edge_cnt_upd <= CNT_W'(EXP_HI));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    freq_d     = freq_q;
    in_range_d = in_range_q;
    ovf_out_d  = ovf_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start || cont) begin
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        state_d    = S_GATE;
      end

      S_GATE: begin
        edge_cnt_d = edge_cnt_upd;
        ovf_d      = ovf_upd;
        if (gate_cnt_q == GATE_LAST) begin
          // Results are loaded on the way into DONE (including an edge on
          // the final gate cycle) so they are already stable while valid
          // is high.
          freq_d     = edge_cnt_upd;
          ovf_out_d  = ovf_upd;
          in_range_d = lo_ok && hi_ok && !ovf_upd;
          state_d    = S_DONE;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here: a request coinciding
        // with DONE is dropped.
        state_d = cont ? S_ARM : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      freq_q     <= '0;
      in_range_q <= 1'b0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      freq_q     <= freq_d;
      in_range_q <= in_range_d;
      ovf_out_q  <= ovf_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all decoded straight from registers
  // --------------------------------------------------------------------------
  assign busy     = (state_q != S_IDLE);
  assign valid    = (state_q == S_DONE);
  assign freq_cnt = freq_q;
  assign in_range = in_range_q;
  assign overflow = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meter
//  Purpose  : Self-checking bench for freq_meter. A measurement-level model
//             (count of rising transitions of the sampled signal inside the
//             gate window) predicts every output on every cycle; a few
//             literal expectations pin the model on known patterns.
//  Revision : 1.0  initial release
// ============================================================================
module tb_freq_meter;

  localparam int G    = 100;
  localparam int CW   = 5;
  localparam int LO   = 10;
  localparam int HI   = 20;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk_in;
  logic          rst_n;
  logic          sig_in;
  logic          start;
  logic          cont;
  logic          busy;
  logic          valid;
  logic [CW-1:0] freq_cnt;
  logic          in_range;
  logic          overflow;

  freq_meter #(
    .GATE_CYCLES (G),
    .CNT_W       (CW),
    .EXP_LO      (LO),
    .EXP_HI      (HI)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .start    (start),
    .cont     (cont),
    .busy     (busy),
    .valid    (valid),
    .freq_cnt (freq_cnt),
    .in_range (in_range),
    .overflow (overflow)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // --------------------------------------------------------------------------
  // Signal generator: toggles every 'half' cycles, or holds 'hold_val'
  // --------------------------------------------------------------------------
  int   half     = 0;
  logic hold_val = 1'b0;

  initial begin
    int tcnt;
    tcnt   = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (half == 0) begin
        sig_in = hold_val;
      end else begin
        tcnt++;
        if (tcnt >= half) begin
          tcnt   = 0;
          sig_in = ~sig_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model. Works at measurement level: a gate triggered at clock
  // edge T counts rising transitions of sig_in (as sampled at edges) whose
  // rising sample falls on edges T .. T+G-1; the result is shown in the DONE
  // cycle that follows edge T+G+1, and the next run decision is taken at
  // edge T+G+2.
  // --------------------------------------------------------------------------
  logic          exp_busy  = 1'b0;
  logic          exp_valid = 1'b0;
  logic [CW-1:0] exp_freq  = '0;
  logic          exp_inr   = 1'b0;
  logic          exp_ovf   = 1'b0;

  initial begin
    int e, t_trig, base, cum, res;
    bit active, prev_s;
    e = 0; t_trig = 0; base = 0; cum = 0; res = 0;
    active = 0; prev_s = 0;
    forever begin
      @(posedge clk_in);
      if (!rst_n) begin
        e = 0; cum = 0; res = 0; active = 0; prev_s = 0;
        exp_busy = 0; exp_valid = 0; exp_freq = '0; exp_inr = 0; exp_ovf = 0;
      end else begin
        e++;
        if (active && e == t_trig + G + 2) begin
          if (cont) begin
            t_trig = e;
            base   = cum;
          end else begin
            active = 0;
          end
        end else if (!active && (start || cont)) begin
          active = 1;
          t_trig = e;
          base   = cum;
        end
        if (sig_in && !prev_s) cum++;
        prev_s = sig_in;
        if (active && e == t_trig + G - 1) res = cum - base;
        exp_valid = active && (e == t_trig + G + 1);
        if (exp_valid) begin
          exp_ovf  = (res > MAXV);
          exp_freq = (res > MAXV) ? CW'(MAXV) : CW'(res);
          exp_inr  = !exp_ovf && (res >= LO) && (res <= HI);
        end
        exp_busy = active;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Literal expectations shared with the stimulus process
  // --------------------------------------------------------------------------
  bit     lit_en   = 0;
  bit     lit_zero = 0;
  int     lit_lo   = 0;
  int     lit_hi   = 0;
  int     lit_inr  = 0;
  int     lit_ovf  = 0;
  longint t_start  = 0;
  int     tmo_cnt  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Single compare process: runs on every falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      chk("busy",       32'(busy),     32'(exp_busy));
      chk("valid",      32'(valid),    32'(exp_valid));
      chk("freq_cnt",   32'(freq_cnt), 32'(exp_freq));
      chk("in_range",   32'(in_range), 32'(exp_inr));
      chk("overflow",   32'(overflow), 32'(exp_ovf));
      chk("wait_bound", 32'(tmo_cnt),  32'(0));
      if (lit_zero) begin
        chk("lit_zero_busy",  32'(busy),     32'(0));
        chk("lit_zero_valid", 32'(valid),    32'(0));
        chk("lit_zero_freq",  32'(freq_cnt), 32'(0));
        chk("lit_zero_ovf",   32'(overflow), 32'(0));
      end
      if (lit_en && valid === 1'b1) begin
        chk("lit_freq_window", 32'((int'(freq_cnt) >= lit_lo) && (int'(freq_cnt) <= lit_hi)), 32'(1));
        chk("lit_in_range",    32'(in_range), 32'(lit_inr));
        chk("lit_overflow",    32'(overflow), 32'(lit_ovf));
        chk("lit_latency",     32'(($time - t_start) / 10), 32'(G + 2));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic wait_valid(input bit poke);
    bit got;
    got = 0;
    for (int k = 0; k < G + 20; k++) begin
      @(negedge clk_in);
      if (valid === 1'b1) begin
        got = 1;
        break;
      end
      start = poke ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
    start = 1'b0;
    if (!got) tmo_cnt++;
  endtask

  task automatic measure_lit(input int h, input logic hv, input int lo, input int hi,
                             input int inr, input int ovf);
    half     = h;
    hold_val = hv;
    repeat (10) @(negedge clk_in);
    lit_lo  = lo;
    lit_hi  = hi;
    lit_inr = inr;
    lit_ovf = ovf;
    lit_en  = 1;
    start   = 1'b1;
    t_start = $time;
    @(negedge clk_in);
    start = 1'b0;
    wait_valid(1'b0);
    @(negedge clk_in);
    #2 lit_en = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cont  = 1'b0;

    // Reset, then idle with no request: everything stays at zero.
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b1;
    lit_zero = 1;
    repeat (100) @(negedge clk_in);
    #2 lit_zero = 0;

    // Known patterns (gate 100 cycles, window 10..20, 5-bit counter).
    measure_lit(4, 1'b0, 12, 13, 1, 0);   // period 8  -> 12/13 edges
    measure_lit(2, 1'b0, 25, 25, 0, 0);   // period 4  -> 25 edges
    measure_lit(1, 1'b0, 31, 31, 0, 1);   // period 2  -> 50 edges, saturates
    measure_lit(0, 1'b1, 0,  0,  0, 0);   // constant high -> no edges

    // Continuous mode with stray start pulses and changing input rate.
    @(negedge clk_in);
    cont = 1'b1;
    half = 3;
    for (int c = 0; c < 5 * (G + 2); c++) begin
      @(negedge clk_in);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) half = $urandom_range(1, 9);
    end
    @(negedge clk_in);
    start = 1'b0;
    wait_valid(1'b0);
    repeat (40) @(negedge clk_in);
    cont = 1'b0;                           // mid-gate: one more result only
    wait_valid(1'b0);
    repeat (2 * G) @(negedge clk_in);

    // Reset in the middle of a gate: result lost, nothing published.
    half = 4;
    repeat (5) @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (50) @(negedge clk_in);
    #2 rst_n = 1'b0;
    lit_zero = 1;
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    #2 lit_zero = 0;
    measure_lit(4, 1'b0, 12, 13, 1, 0);

    // Random single measurements with ignored start pulses while busy.
    for (int m = 0; m < 12; m++) begin
      half     = $urandom_range(0, 8);
      hold_val = 1'($urandom_range(0, 1));
      repeat ($urandom_range(3, 20)) @(negedge clk_in);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      wait_valid(1'b1);
      repeat (3) @(negedge clk_in);
    end

    repeat (3) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
